// File: rtl/encoder32_5_pipe_if.sv
// Handshake bundle for the registered 32:5 one-hot encoder.
// The master modport is the producer/consumer side; the slave modport is the encoder.
interface encoder32_5_pipe_if #(
    parameter int N_IN   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_onehot;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output in_valid, in_onehot, out_ready,
        input  in_ready, out_valid, out_addr, out_err, err_count
    );

    modport slave (
        input  in_valid, in_onehot, out_ready,
        output in_ready, out_valid, out_addr, out_err, err_count
    );
endinterface

// File: rtl/encoder32_5_pipe.sv
// Registered 32:5 encoder with valid/ready handshake, one-hot error flag and saturating error counter.
// Build option ENCODER_PRIORITY_EN: multi-hot inputs resolve to the highest set index instead of erroring.
module encoder32_5_pipe #(
    parameter int N_IN   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    encoder32_5_pipe_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                out_valid_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                retire_s;
    logic [ADDR_W:0]     enc_s;
    logic [ADDR_W-1:0]   addr_r;
    logic                err_r;
    logic [CNT_W-1:0]    cnt_r;

    // Result packed as {err, addr}.
`ifdef ENCODER_PRIORITY_EN
    function automatic logic [ADDR_W:0] encode_f(input logic [N_IN-1:0] v);
        logic [ADDR_W-1:0] idx;
        logic              err;
        idx = {ADDR_W{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            if (v[i]) begin
                idx = i[ADDR_W-1:0];
            end else begin
                idx = idx;
            end
        end
        err = (v == {N_IN{1'b0}});
        return {err, idx};
    endfunction
`else
    function automatic logic [ADDR_W:0] encode_f(input logic [N_IN-1:0] v);
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W:0]   ones;
        idx  = {ADDR_W{1'b0}};
        ones = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            if (v[i]) begin
                idx  = i[ADDR_W-1:0];
                ones = ones + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                idx  = idx;
                ones = ones;
            end
        end
        if (ones == {{ADDR_W{1'b0}}, 1'b1}) begin
            return {1'b0, idx};
        end else begin
            return {1'b1, {ADDR_W{1'b0}}};
        end
    endfunction
`endif

    assign accept_s = bus.in_valid && in_ready_s;
    assign retire_s = out_valid_s && bus.out_ready;
    assign enc_s    = encode_f(bus.in_onehot);

    // State register: EMPTY/FULL occupancy of the single result slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: fill on accept, drain on retire without a replacement.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (retire_s && !accept_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Output decode: slot occupancy drives valid, ready opens when empty or draining.
    always_comb begin
        out_valid_s = 1'b0;
        case (state_r)
            ST_EMPTY: out_valid_s = 1'b0;
            ST_FULL:  out_valid_s = 1'b1;
            default:  out_valid_s = 1'b0;
        endcase
        in_ready_s = !out_valid_s || bus.out_ready;
    end

    // Result register: captures the encoding only on an accepting edge, else holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r <= {ADDR_W{1'b0}};
            err_r  <= 1'b0;
        end else if (accept_s) begin
            addr_r <= enc_s[ADDR_W-1:0];
            err_r  <= enc_s[ADDR_W];
        end else begin
            addr_r <= addr_r;
            err_r  <= err_r;
        end
    end

    // Error counter: counts accepted erroneous inputs and sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s && enc_s[ADDR_W] && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_addr  = addr_r;
    assign bus.out_err   = err_r;
    assign bus.err_count = cnt_r;

endmodule

// File: doc/encoder32_5_pipe.md
Name: encoder32_5_pipe

Overview:
- Registered 32:5 encoder: the inverse of the 5:32 register-select decoder.
- Converts a 32-bit one-hot select vector back into a 5-bit register index.
- Used to recover a register number from one-hot enable/forwarding lines, e.g. for hazard compare and debug trace.
- Single output register stage, valid/ready handshake on both sides, one-hot error detection and a saturating error counter.

Parameters:
- N_IN, 32, number of one-hot input lines; must equal 2**ADDR_W.
- ADDR_W, 5, encoded index width.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_valid  input  1  in_onehot is presented.
- in_ready  output  1  block can accept this cycle.
- in_onehot  input  N_IN  select vector; bit k means index k.
- out_valid  output  1  out_addr/out_err hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_addr  output  ADDR_W  encoded index.
- out_err  output  1  input was not exactly one-hot.
- err_count  output  CNT_W  number of accepted erroneous inputs, saturating.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_addr=0, out_err=0, err_count=0. A transfer in flight is discarded. in_ready reads 1 while in reset.
- in_ready = !out_valid || out_ready (combinational). This is a single-entry pipeline register, so full throughput is one result per cycle.
- Input accept: in_valid && in_ready at a rising clk edge. On the next edge the result registers; out_valid=1 the cycle after acceptance, so latency is exactly 1.
- Output retire: out_valid && out_ready at an edge. If no simultaneous accept, out_valid goes to 0 and out_addr/out_err keep their last values.
- Simultaneous accept and retire: the new result replaces the old in the same edge and out_valid stays 1. No bubble, no loss.
- Stall: out_valid && !out_ready. in_ready=0, and out_addr, out_err and out_valid are held stable. Inputs presented while stalled are ignored.
- Encoding, exactly one bit k set: out_addr=k, out_err=0.
- Encoding, zero bits set: out_addr=0, out_err=1.
- Encoding, two or more bits set: governed by the Optional Feature.
- err_count increments by 1 on each accepted input whose result has out_err=1. It saturates at 2**CNT_W-1 (255) and never wraps.
- err_count is cleared only by reset.
- The state is conceptually two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY goes to FULL on accept.
  - FULL goes to EMPTY on retire without accept.
  - FULL stays FULL on accept with retire, or on stall.
- in_onehot is sampled only at an accepting edge. X or changes between edges have no effect.

Optional Feature:
- Macro: ENCODER_PRIORITY_EN.
- Defined: multi-hot input resolves to the highest set index, with out_err=0. Only the all-zero input sets out_err and increments err_count.
- Undefined: multi-hot input gives out_addr=0, out_err=1 and increments err_count.
- The zero-hot behaviour is identical in both builds.

Test Plan:
- Reset low mid-transfer (out_valid=1, out_addr=5'd9) -> immediately out_valid=0, out_addr=0, err_count=0, in_ready=1.
- Accept in_onehot=32'h0000_0010 with out_ready=1 -> next cycle out_valid=1, out_addr=5'd4, out_err=0. Sweep all 32 one-hot values back-to-back -> out_addr=0..31 in order, no bubbles.
- in_onehot=32'h0000_0000 accepted -> out_addr=0, out_err=1, err_count=1.
- in_onehot=32'h8000_0001:
  - without macro -> out_addr=0, out_err=1, err_count increments.
  - with ENCODER_PRIORITY_EN -> out_addr=5'd31, out_err=0, err_count unchanged.
- Hold out_ready=0 for 3 cycles after a result for index 7 -> in_ready=0, out_addr stays 7, and an input offered meanwhile (32'h0000_0100) is not taken. Release out_ready -> index 7 retires, then index 8 is accepted and appears one cycle later.
- Apply 300 accepted zero-hot inputs -> err_count reaches 255 and stays 255.
